// File: rtl/apb_master_arb_if.sv
// Bundles the two requester ports and the APB master bus of apb_master_arb.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface apb_master_arb_if #(
  parameter int W = 8,
  parameter int D = 8
);
  logic         req0;
  logic         wr0;
  logic [D-1:0] addr0;
  logic [W-1:0] wdata0;
  logic         req1;
  logic         wr1;
  logic [D-1:0] addr1;
  logic [W-1:0] wdata1;
  logic         done0;
  logic         done1;
  logic [W-1:0] rdata;
  logic         err;
  logic         psel;
  logic         penable;
  logic         pwrite;
  logic [D-1:0] paddr;
  logic [W-1:0] pw_data;
  logic [W-1:0] pr_data;
  logic         pready;
  logic         pslverr;

  modport master (
    input  req0, wr0, addr0, wdata0,
    input  req1, wr1, addr1, wdata1,
    output done0, done1, rdata, err,
    output psel, penable, pwrite, paddr, pw_data,
    input  pr_data, pready, pslverr
  );

  modport slave (
    output req0, wr0, addr0, wdata0,
    output req1, wr1, addr1, wdata1,
    input  done0, done1, rdata, err,
    input  psel, penable, pwrite, paddr, pw_data,
    output pr_data, pready, pslverr
  );
endinterface

// File: rtl/apb_master_arb.sv
// Two-requester round-robin APB master: each grant becomes one APB transfer with
// an address range check and a pready timeout. All outputs are registered.
//
// state  | meaning
// IDLE   | sample requests, arbitrate, latch winner, range check
// SETUP  | psel=1, penable=0, address/data/direction presented
// ACCESS | psel=1, penable=1, wait for pready or timeout
// DONE   | one-cycle done pulse to the granted port, update rr pointer
module apb_master_arb #(
  parameter int W        = 8,
  parameter int D        = 8,
  parameter int MAX_ADDR = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 preset,
  apb_master_arb_if.master     bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic          gnt, gnt_nxt;
  logic          pri, pri_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          psel_nxt, penable_nxt, pwrite_nxt;
  logic [D-1:0]  paddr_nxt;
  logic [W-1:0]  pw_data_nxt, rdata_nxt;
  logic          err_nxt, done0_nxt, done1_nxt;
  logic          win;
  logic [D-1:0]  win_addr;

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      pri         <= 1'b0;
      cnt         <= '0;
      bus.psel    <= 1'b0;
      bus.penable <= 1'b0;
      bus.pwrite  <= 1'b0;
      bus.paddr   <= '0;
      bus.pw_data <= '0;
      bus.rdata   <= '0;
      bus.err     <= 1'b0;
      bus.done0   <= 1'b0;
      bus.done1   <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      pri         <= pri_nxt;
      cnt         <= cnt_nxt;
      bus.psel    <= psel_nxt;
      bus.penable <= penable_nxt;
      bus.pwrite  <= pwrite_nxt;
      bus.paddr   <= paddr_nxt;
      bus.pw_data <= pw_data_nxt;
      bus.rdata   <= rdata_nxt;
      bus.err     <= err_nxt;
      bus.done0   <= done0_nxt;
      bus.done1   <= done1_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    pri_nxt     = pri;
    cnt_nxt     = cnt;
    psel_nxt    = bus.psel;
    penable_nxt = bus.penable;
    pwrite_nxt  = bus.pwrite;
    paddr_nxt   = bus.paddr;
    pw_data_nxt = bus.pw_data;
    rdata_nxt   = bus.rdata;
    err_nxt     = bus.err;
    done0_nxt   = 1'b0;
    done1_nxt   = 1'b0;
    // pri names the port that wins a tie; a lone request always wins
    win         = (bus.req0 && bus.req1) ? pri : bus.req1;
    win_addr    = win ? bus.addr1 : bus.addr0;

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_nxt = win;
          if (win_addr > D'(MAX_ADDR)) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
            rdata_nxt = '0;
            done0_nxt = ~win;
            done1_nxt = win;
          end else begin
            state_nxt   = SETUP;
            psel_nxt    = 1'b1;
            penable_nxt = 1'b0;
            pwrite_nxt  = win ? bus.wr1 : bus.wr0;
            paddr_nxt   = win_addr;
            pw_data_nxt = win ? bus.wdata1 : bus.wdata0;
            cnt_nxt     = '0;
          end
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        if (bus.pready) begin
          state_nxt   = DONE;
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          err_nxt     = bus.pslverr;
          rdata_nxt   = bus.pwrite ? '0 : bus.pr_data;
          done0_nxt   = ~gnt;
          done1_nxt   = gnt;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt   = DONE;
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          err_nxt     = 1'b1;
          rdata_nxt   = '0;
          done0_nxt   = ~gnt;
          done1_nxt   = gnt;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        pri_nxt   = ~gnt;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
